// File: rtl/branch_resolve_pkg.sv
// Shared types for branch resolution: front-end prediction record and BPU update record.
package branch_resolve_pkg;
   localparam logic [1:0] BIsNone = 2'd0;
   localparam logic [1:0] BIsImme = 2'd1;
   localparam logic [1:0] BIsCall = 2'd2;
   localparam logic [1:0] BIsRetn = 2'd3;

   typedef struct packed {
      logic        IsTaken;
      logic [31:0] Target;
      logic [1:0]  Type;
      logic [1:0]  Count;
      logic        Hit;
      logic        Valid;
   } presult_t;

   typedef struct packed {
      logic        Valid;
      logic [31:0] PC;
      logic [31:0] Target;
      logic [1:0]  Type;
      logic [1:0]  Count;
      logic        Hit;
      logic        IsTaken;
   } bresult_t;
endpackage

// File: rtl/branch_resolve.sv
// EXE-stage branch resolution: mispredict detection, delay-slot aware redirect,
// BPU update record and performance counters.
//
// state   | meaning
// IDLE    | resolving instructions in EXE
// WAIT_DS | mispredict seen, waiting for its delay slot to reach ID
// FLUSH   | one-cycle IF_Flush / redirect pulse
module branch_resolve
   import branch_resolve_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        EXE_Valid,
   input  logic        EXE_Stall,
   input  logic [31:0] EXE_PC,
   input  presult_t    EXE_PResult,
   input  logic [1:0]  EXE_Type,
   input  logic        EXE_Taken,
   input  logic [31:0] EXE_ActTarget,
   input  logic        DS_InPipe,
   input  logic        EXC_Flush,
   output bresult_t    EXE_BResult,
   output logic        IF_Flush,
   output logic        Redirect_Valid,
   output logic [31:0] Redirect_PC,
   output logic [31:0] BranchCnt,
   output logic [31:0] MissCnt
);

   typedef enum logic [1:0] {IDLE, WAIT_DS, FLUSH} state_e;

   state_e      state;
   logic        done;
   logic [31:0] cpc_q;

   logic        pt;
   logic        act_taken;
   logic        mispredict;
   logic        resolve;
   logic [31:0] cpc;

   always_comb begin
      pt         = EXE_PResult.Valid & EXE_PResult.IsTaken;
      act_taken  = (EXE_Type != BIsNone) & EXE_Taken;
      mispredict = (pt != act_taken) |
                   (pt & act_taken & (EXE_PResult.Target != EXE_ActTarget));
      cpc        = act_taken ? EXE_ActTarget : EXE_PC + 32'd8;
      resolve    = EXE_Valid & ~done & (state == IDLE);
   end

   // done stays set while the resolved instruction is held in EXE
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         done <= 1'b0;
      else if (!EXE_Stall)
         done <= 1'b0;
      else if (resolve)
         done <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cpc_q          <= 32'd0;
         IF_Flush       <= 1'b0;
         Redirect_Valid <= 1'b0;
         Redirect_PC    <= 32'd0;
      end else begin
         IF_Flush       <= 1'b0;
         Redirect_Valid <= 1'b0;
         Redirect_PC    <= 32'd0;
         if (EXC_Flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (resolve && mispredict) begin
                     cpc_q <= cpc;
                     if (DS_InPipe) begin
                        state          <= FLUSH;
                        IF_Flush       <= 1'b1;
                        Redirect_Valid <= 1'b1;
                        Redirect_PC    <= cpc;
                     end else begin
                        state <= WAIT_DS;
                     end
                  end
               end
               WAIT_DS: begin
                  if (DS_InPipe) begin
                     state          <= FLUSH;
                     IF_Flush       <= 1'b1;
                     Redirect_Valid <= 1'b1;
                     Redirect_PC    <= cpc_q;
                  end
               end
               FLUSH:   state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Hit on a non-branch still produces an update so the aliased entry is cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         EXE_BResult <= '0;
      end else begin
         EXE_BResult.Valid <= resolve & ((EXE_Type != BIsNone) | EXE_PResult.Hit);
         if (resolve) begin
            EXE_BResult.PC      <= EXE_PC;
            EXE_BResult.Target  <= EXE_ActTarget;
            EXE_BResult.Type    <= EXE_Type;
            EXE_BResult.Count   <= EXE_PResult.Count;
            EXE_BResult.Hit     <= EXE_PResult.Hit;
            EXE_BResult.IsTaken <= EXE_Taken;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         BranchCnt <= 32'd0;
         MissCnt   <= 32'd0;
      end else if (resolve) begin
         if ((EXE_Type != BIsNone) && (BranchCnt != 32'hFFFF_FFFF))
            BranchCnt <= BranchCnt + 32'd1;
         if (mispredict && (MissCnt != 32'hFFFF_FFFF))
            MissCnt <= MissCnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized scoreboard bench for branch_resolve with directed corner cases.
module tb_branch_resolve;
   import branch_resolve_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        EXE_Valid = 1'b0;
   logic        EXE_Stall = 1'b0;
   logic [31:0] EXE_PC = 32'd0;
   presult_t    EXE_PResult = '0;
   logic [1:0]  EXE_Type = 2'd0;
   logic        EXE_Taken = 1'b0;
   logic [31:0] EXE_ActTarget = 32'd0;
   logic        DS_InPipe = 1'b0;
   logic        EXC_Flush = 1'b0;
   bresult_t    EXE_BResult;
   logic        IF_Flush;
   logic        Redirect_Valid;
   logic [31:0] Redirect_PC;
   logic [31:0] BranchCnt;
   logic [31:0] MissCnt;

   branch_resolve dut (
      .clk(clk), .rst(rst), .EXE_Valid(EXE_Valid), .EXE_Stall(EXE_Stall),
      .EXE_PC(EXE_PC), .EXE_PResult(EXE_PResult), .EXE_Type(EXE_Type),
      .EXE_Taken(EXE_Taken), .EXE_ActTarget(EXE_ActTarget), .DS_InPipe(DS_InPipe),
      .EXC_Flush(EXC_Flush), .EXE_BResult(EXE_BResult), .IF_Flush(IF_Flush),
      .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
      .BranchCnt(BranchCnt), .MissCnt(MissCnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct { int cyc; bresult_t b; } bexp_t;
   typedef struct { int cyc; logic [31:0] pc; } rexp_t;
   bexp_t bq[$];
   rexp_t rq[$];

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m_branch = 32'd0;
   logic [31:0] m_miss   = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_bresult_zero"}, {31'd0, EXE_BResult != '0}, 32'd0);
      chk({tag, "_if_flush"}, {31'd0, IF_Flush}, 32'd0);
      chk({tag, "_redirect_valid"}, {31'd0, Redirect_Valid}, 32'd0);
      chk({tag, "_redirect_pc"}, Redirect_PC, 32'd0);
      chk({tag, "_branch_cnt"}, BranchCnt, 32'd0);
      chk({tag, "_miss_cnt"}, MissCnt, 32'd0);
   endtask

   // Monitor: pops expectations whenever the DUT presents an update or redirect
   always @(negedge clk) begin
      if (!rst) begin
         if (bq.size() > 0 && bq[0].cyc < cyc) begin
            chk("bresult_missing", 32'd0, 32'd1);
            void'(bq.pop_front());
         end
         if (rq.size() > 0 && rq[0].cyc < cyc) begin
            chk("redirect_missing", 32'd0, 32'd1);
            void'(rq.pop_front());
         end
         if (EXE_BResult.Valid) begin
            if (bq.size() == 0) begin
               chk("bresult_unexpected", 32'd1, 32'd0);
            end else begin
               bexp_t e;
               e = bq.pop_front();
               chk("bresult_cycle", cyc, e.cyc);
               n_vec++;
               if (EXE_BResult != e.b) begin
                  n_err++;
                  $display("FAIL bresult_fields: got %h expected %h", EXE_BResult, e.b);
               end
            end
         end
         if (IF_Flush || Redirect_Valid) begin
            if (rq.size() == 0) begin
               chk("redirect_unexpected", 32'd1, 32'd0);
            end else begin
               rexp_t e;
               e = rq.pop_front();
               chk("redirect_cycle", cyc, e.cyc);
               chk("redirect_pair", {30'd0, IF_Flush, Redirect_Valid}, 32'd3);
               chk("redirect_pc", Redirect_PC, e.pc);
            end
         end
      end
   end

   task automatic drive_fields(input logic [31:0] pc, input presult_t pr, input logic [1:0] ty,
                               input logic tk, input logic [31:0] tgt);
      EXE_PC = pc; EXE_PResult = pr; EXE_Type = ty; EXE_Taken = tk; EXE_ActTarget = tgt;
   endtask

   task automatic idle(input int c);
      for (int i = 0; i < c; i++) begin
         @(negedge clk);
         EXE_Valid = 1'b0; EXE_Stall = 1'b0; DS_InPipe = 1'b0; EXC_Flush = 1'b0;
      end
   endtask

   task automatic check_counters(input string tag);
      idle(1);
      @(negedge clk);
      chk({tag, "_branch_cnt"}, BranchCnt, m_branch);
      chk({tag, "_miss_cnt"}, MissCnt, m_miss);
   endtask

   // abort: 0 none, 1 EXC_Flush while waiting, 2 reset while waiting, 3 EXC_Flush on resolve
   task automatic do_instr(input logic [31:0] pc, input presult_t pr, input logic [1:0] ty,
                           input logic tk, input logic [31:0] tgt, input int s, input int d,
                           input bit junk, input int abort);
      bit pt, act, mis;
      logic [31:0] cpc;
      int n, r;
      bexp_t be;
      rexp_t re;
      pt  = pr.Valid && pr.IsTaken;
      act = (ty != BIsNone) && tk;
      mis = (pt != act) || (pt && act && (pr.Target != tgt));
      cpc = act ? tgt : pc + 32'd8;
      n = s + 1;
      if (mis && (d + 2 > n)) n = d + 2;
      if (junk && mis) n = d + 2;
      @(negedge clk);
      r = cyc + 1;
      if (ty != BIsNone || pr.Hit) begin
         be.cyc = r;
         be.b = '{Valid: 1'b1, PC: pc, Target: tgt, Type: ty, Count: pr.Count,
                  Hit: pr.Hit, IsTaken: tk};
         bq.push_back(be);
      end
      if (mis && abort == 0) begin
         re.cyc = r + d;
         re.pc = cpc;
         rq.push_back(re);
      end
      if (ty != BIsNone && m_branch != 32'hFFFF_FFFF) m_branch++;
      if (mis && m_miss != 32'hFFFF_FFFF) m_miss++;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         if (abort == 2 && k == 2) begin
            rst = 1'b1;
            EXE_Valid = 1'b0;
            #1;
            chk_zero_outputs("midrst");
            m_branch = 32'd0;
            m_miss = 32'd0;
         end
         if (abort == 2 && k == 3) rst = 1'b0;
         EXC_Flush = (abort == 1 && k == 1) || (abort == 3 && k == 0);
         DS_InPipe = mis ? (k >= d) : 1'($urandom_range(0, 1));
         if (abort == 2 && k >= 2) begin
            EXE_Valid = 1'b0;
         end else if (junk && mis && k > 0) begin
            EXE_Valid = 1'b1;
            EXE_Stall = 1'b0;
            drive_fields($urandom & ~32'd3, presult_t'({$urandom, $urandom, $urandom}),
                         2'($urandom), 1'($urandom), $urandom & ~32'd3);
         end else begin
            EXE_Valid = 1'b1;
            EXE_Stall = (k < n - 1) && !(junk && mis);
            drive_fields(pc, pr, ty, tk, tgt);
         end
      end
   endtask

   function automatic presult_t mk_pr(input logic v, input logic t, input logic [31:0] tg,
                                      input logic h);
      presult_t p;
      p = '0;
      p.Valid = v; p.IsTaken = t; p.Target = tg; p.Hit = h; p.Count = 2'd2;
      return p;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #2;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      do_instr(32'h100, mk_pr(0, 0, 32'h0, 0), BIsImme, 1'b0, 32'h180, 0, 0, 0, 0);
      check_counters("not_taken");
      do_instr(32'h200, mk_pr(0, 0, 32'h0, 0), BIsImme, 1'b1, 32'h400, 0, 0, 0, 0);
      check_counters("mis_taken");
      do_instr(32'h300, mk_pr(1, 1, 32'h500, 1), BIsImme, 1'b0, 32'h500, 0, 3, 0, 0);
      check_counters("ds_late");
      do_instr(32'h600, mk_pr(1, 1, 32'h640, 1), BIsCall, 1'b1, 32'h640, 4, 0, 0, 0);
      check_counters("stall");
      do_instr(32'h800, mk_pr(1, 1, 32'h880, 1), BIsImme, 1'b1, 32'h8C0, 0, 3, 0, 1);
      idle(3);
      check_counters("exc_wait");
      do_instr(32'h840, mk_pr(0, 0, 32'h0, 0), BIsRetn, 1'b1, 32'hA00, 0, 0, 0, 3);
      check_counters("exc_same");
      do_instr(32'h900, mk_pr(0, 0, 32'h0, 0), BIsImme, 1'b1, 32'h980, 0, 3, 0, 2);
      idle(3);
      check_counters("rst_wait");
      do_instr(32'h700, mk_pr(1, 1, 32'h900, 1), BIsNone, 1'b1, 32'h900, 0, 1, 0, 0);
      do_instr(32'hFFFF_FFFC, mk_pr(1, 1, 32'h40, 0), BIsNone, 1'b0, 32'h40, 0, 0, 0, 0);
      do_instr(32'h740, mk_pr(1, 1, 32'h111, 1), BIsImme, 1'b1, 32'h222, 0, 2, 1, 0);
      check_counters("alias");

      for (int i = 0; i < 300; i++) begin
         logic [31:0] pc, tgt;
         presult_t pr;
         pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'd3);
         tgt = $urandom & ~32'd3;
         pr  = presult_t'({$urandom, $urandom, $urandom});
         pr.Target = $urandom_range(0, 1) ? tgt : ($urandom & ~32'd3);
         do_instr(pc, pr, 2'($urandom), 1'($urandom), tgt, $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom), 0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         if (i % 50 == 49) check_counters("random");
      end

      idle(5);
      chk("bq_drained", bq.size(), 32'd0);
      chk("rq_drained", rq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
